accel_uart_sequencer: RTL and testbench

Command/response sequencer between the UART receiver, the accelerometer SPI reader and the UART transmitter. It decodes single-byte axis commands ('x', 'y', 'z') from the receiver and drives the axis select into the SPI reader. After a settle interval it latches the 16-bit sample and streams a framed response through the transmitter, strictly one byte per `tx_busy` cycle. It replaces the ad-hoc busy/ready-edge logic in the serial top level with a single synchronous FSM.

---
 rtl/accel_seq_pkg.sv | 16 +
 rtl/accel_uart_sequencer_tx.sv | 46 ++++
 rtl/accel_uart_sequencer.sv | 100 ++++++++++
 tb/tb_accel_uart_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/accel_seq_pkg.sv
// accel_seq_pkg: shared states, command codes and frame sizing for the accelerometer UART sequencer.
package accel_seq_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_LATCH, S_SEND, S_WAIT_HI, S_WAIT_LO, S_NEXT
   } state_e;
   localparam logic [7:0] CMD_X = 8'h78;
   localparam logic [7:0] CMD_Y = 8'h79;
   localparam logic [7:0] CMD_Z = 8'h7A;
   localparam logic [2:0] AXIS_X = 3'd0;
   localparam logic [2:0] AXIS_Y = 3'd1;
   localparam logic [2:0] AXIS_Z = 3'd2;
   localparam int MAX_FRAME = 5;
   function automatic logic is_axis_cmd(input logic [7:0] b);
      return b == CMD_X || b == CMD_Y || b == CMD_Z;
   endfunction
endpackage

// File: rtl/accel_uart_sequencer_tx.sv
// tx_byte_handshake: hands one byte to the UART transmitter and waits for its busy high/low pair.
module tx_byte_handshake
   import accel_seq_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       go_i,
   input  logic [7:0] byte_i,
   input  logic       tx_busy_i,
   output logic       tx_start_o,
   output logic [7:0] tx_data_o,
   output logic       done_o
);
   state_e hs_q, hs_d;
   logic tx_start_q, tx_start_d;
   logic [7:0] tx_data_q, tx_data_d;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hs_q <= S_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q <= 8'h00;
      end else begin
         hs_q <= hs_d;
         tx_start_q <= tx_start_d;
         tx_data_q <= tx_data_d;
      end
   end
   always_comb begin
      hs_d = hs_q;
      case (hs_q)
         S_IDLE: hs_d = go_i ? S_SEND : S_IDLE;
         S_SEND: hs_d = tx_start_q ? S_WAIT_HI : S_SEND;
         S_WAIT_HI: hs_d = tx_busy_i ? S_WAIT_LO : S_WAIT_HI;
         S_WAIT_LO: hs_d = tx_busy_i ? S_WAIT_LO : S_IDLE;
         default: hs_d = S_IDLE;
      endcase
   end
   // start is registered for the cycle we sit in SEND, so it is raised only from an idle transmitter
   always_comb begin
      tx_start_d = hs_d == S_SEND && !tx_busy_i;
      tx_data_d = hs_q == S_IDLE && go_i ? byte_i : tx_data_q;
   end
   assign tx_start_o = tx_start_q;
   assign tx_data_o = tx_data_q;
   assign done_o = hs_q == S_WAIT_LO && !tx_busy_i;
endmodule

// File: rtl/accel_uart_sequencer.sv
// accel_uart_sequencer: decodes axis commands, settles, latches the sample and streams the response frame.
// Define ACCEL_SEQ_CHECKSUM_EN to append an XOR checksum byte to ACK frames.
module accel_uart_sequencer
   import accel_seq_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter logic [7:0] HDR_BYTE = 8'hA5,
   parameter logic [7:0] NAK_BYTE = 8'h15
) (
   input  logic        CLK_50,
   input  logic        areset,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready,
   input  logic [15:0] sample,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic [2:0]  dimension,
   output logic        seq_busy,
   output logic [7:0]  drop_cnt
);
   localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
`ifdef ACCEL_SEQ_CHECKSUM_EN
   localparam logic [2:0] ACK_LEN = 3'(MAX_FRAME);
`else
   localparam logic [2:0] ACK_LEN = 3'(MAX_FRAME - 1);
`endif
   state_e state_q, state_d;
   logic [2:0] dim_q, dim_d, idx_q, idx_d, cmd_dim, len;
   logic [CW-1:0] cnt_q, cnt_d;
   logic nak_q, nak_d, take, go, done;
   logic [15:0] sample_q, sample_d;
   logic [7:0] drop_q, drop_d, axis_chr, chk, byte_sel;
   always_ff @(posedge CLK_50 or posedge areset) begin
      if (areset) begin
         state_q <= S_IDLE;
         dim_q <= AXIS_X;
         cnt_q <= '0;
         idx_q <= '0;
         nak_q <= 1'b0;
         sample_q <= '0;
         drop_q <= '0;
      end else begin
         state_q <= state_d;
         dim_q <= dim_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         nak_q <= nak_d;
         sample_q <= sample_d;
         drop_q <= drop_d;
      end
   end
   assign take = state_q == S_IDLE && rx_ready;
   assign cmd_dim = 3'(rx_data - CMD_X);
   assign len = nak_q ? 3'd1 : ACK_LEN;
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: state_d = !take ? S_IDLE : !is_axis_cmd(rx_data) ? S_SEND : cmd_dim != dim_q ? S_SETTLE : S_LATCH;
         S_SETTLE: state_d = cnt_q == '0 ? S_LATCH : S_SETTLE;
         S_LATCH: state_d = S_SEND;
         S_SEND: state_d = done ? S_NEXT : S_SEND;
         S_NEXT: state_d = idx_q == len - 3'd1 ? S_IDLE : S_SEND;
         default: state_d = S_IDLE;
      endcase
   end
   always_comb begin
      dim_d = take && is_axis_cmd(rx_data) ? cmd_dim : dim_q;
      nak_d = take ? !is_axis_cmd(rx_data) : nak_q;
      cnt_d = state_q == S_SETTLE ? cnt_q - CW'(1) : CW'(SETTLE_CYCLES - 1);
      idx_d = state_q != S_NEXT ? idx_q : state_d == S_IDLE ? 3'd0 : idx_q + 3'd1;
      sample_d = state_q == S_LATCH ? sample : sample_q;
      drop_d = rx_ready && state_q != S_IDLE && drop_q != 8'hFF ? drop_q + 8'd1 : drop_q;
   end
   // frame bytes are derived from the latched sample and axis rather than stored separately
   assign axis_chr = CMD_X + {5'd0, dim_q};
`ifdef ACCEL_SEQ_CHECKSUM_EN
   assign chk = axis_chr ^ sample_q[7:0] ^ sample_q[15:8];
`else
   assign chk = 8'h00;
`endif
   always_comb begin
      go = state_d == S_SEND && state_q != S_SEND;
      byte_sel = nak_d ? NAK_BYTE : idx_d == 3'd0 ? HDR_BYTE : idx_d == 3'd1 ? axis_chr :
                 idx_d == 3'd2 ? sample_q[7:0] : idx_d == 3'd3 ? sample_q[15:8] : chk;
   end
   assign dimension = dim_q;
   assign seq_busy = state_q != S_IDLE;
   assign drop_cnt = drop_q;
   tx_byte_handshake u_hs (
      .clk_i(CLK_50),
      .rst_i(areset),
      .go_i(go),
      .byte_i(byte_sel),
      .tx_busy_i(tx_busy),
      .tx_start_o(tx_start),
      .tx_data_o(tx_data),
      .done_o(done)
   );
endmodule

// File: tb/tb_accel_uart_sequencer.sv
// tb_accel_uart_sequencer: directed stimulus with an expected-byte scoreboard and a busy-holding transmitter model.
module tb_accel_uart_sequencer;
   localparam int S = 16;
   logic CLK_50 = 1'b0, areset = 1'b1, rx_ready = 1'b0, tx_busy = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [15:0] sample = 16'h0000;
   logic tx_start, seq_busy;
   logic [7:0] tx_data, drop_cnt;
   logic [2:0] dimension;
   int errors = 0, checks = 0, busy_len = 10, bcnt = 0, sent;
   logic [7:0] exp_q[$];
   longint start_t[$];
   longint tn;

   accel_uart_sequencer #(.SETTLE_CYCLES(S)) dut (
      .CLK_50(CLK_50), .areset(areset), .rx_data(rx_data), .rx_ready(rx_ready),
      .sample(sample), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
      .dimension(dimension), .seq_busy(seq_busy), .drop_cnt(drop_cnt)
   );

   always #10 CLK_50 = ~CLK_50;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // transmitter: every accepted start holds busy for busy_len cycles; bytes are popped from the scoreboard
   always @(negedge CLK_50) begin
      if (tx_start) begin
         start_t.push_back($time);
         chk("start_while_busy", tx_busy, 1'b0);
         chk("byte_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) chk("tx_byte", tx_data, exp_q.pop_front());
         bcnt = busy_len;
      end else if (bcnt > 0) bcnt--;
      tx_busy = bcnt > 0;
   end

   task automatic push_ack(input logic [7:0] c, input logic [15:0] s);
      exp_q.push_back(8'hA5);
      exp_q.push_back(c);
      exp_q.push_back(s[7:0]);
      exp_q.push_back(s[15:8]);
`ifdef ACCEL_SEQ_CHECKSUM_EN
      exp_q.push_back(c ^ s[7:0] ^ s[15:8]);
`endif
   endtask

   task automatic send(input logic [7:0] b);
      start_t.delete();
      @(negedge CLK_50);
      rx_data = b;
      rx_ready = 1'b1;
      @(posedge CLK_50);
      tn = $time;
      #1 rx_ready = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (seq_busy && n < 5000) begin
         @(negedge CLK_50);
         n++;
      end
      chk(tag, seq_busy, 1'b0);
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tx_start"}, tx_start, 1'b0);
      chk({tag, "_tx_data"}, tx_data, 8'h00);
      chk({tag, "_dimension"}, dimension, 3'd0);
      chk({tag, "_seq_busy"}, seq_busy, 1'b0);
      chk({tag, "_drop_cnt"}, drop_cnt, 8'd0);
   endtask

`ifdef ACCEL_SEQ_CHECKSUM_EN
   localparam int ACK_N = 5;
`else
   localparam int ACK_N = 4;
`endif

   initial begin
      repeat (3) @(negedge CLK_50);
      chk_reset("reset");
      areset = 1'b0;

      sample = 16'h1234;
      push_ack(8'h78, 16'h1234);
      send(8'h78);
      chk("x_dimension", dimension, 3'd0);
      chk("x_seq_busy", seq_busy, 1'b1);
      wait_idle("x_idle");
      chk("x_nbytes", start_t.size(), ACK_N);
      if (start_t.size() >= 2) begin
         chk("x_first_start", 32'(start_t[0] - tn), 30);
         chk("x_byte_gap", 32'(start_t[1] - start_t[0]), 20 * busy_len + 40);
      end

      sample = 16'hBEEF;
      push_ack(8'h79, 16'hBEEF);
      send(8'h79);
      chk("y_dimension", dimension, 3'd1);
      wait_idle("y_idle");
      chk("y_nbytes", start_t.size(), ACK_N);
      if (start_t.size() >= 1) chk("y_settle_start", 32'(start_t[0] - tn), 20 * S + 30);

      exp_q.push_back(8'h15);
      send(8'h41);
      chk("nak_dimension", dimension, 3'd1);
      chk("nak_seq_busy", seq_busy, 1'b1);
      wait_idle("nak_idle");
      chk("nak_nbytes", start_t.size(), 1);

      sample = 16'h5A3C;
      push_ack(8'h78, 16'h5A3C);
      send(8'h78);
      sent = 0;
      for (int i = 0; i < 3; i++) begin
         repeat (4) @(negedge CLK_50);
         if (seq_busy) begin
            rx_data = 8'h7A;
            rx_ready = 1'b1;
            sent++;
            @(posedge CLK_50);
            #1 rx_ready = 1'b0;
         end
      end
      chk("drop3_sent", sent, 3);
      chk("drop3_dimension", dimension, 3'd0);
      wait_idle("drop3_idle");
      chk("drop3_cnt", drop_cnt, 8'd3);

      busy_len = 200;
      sample = 16'h0102;
      push_ack(8'h79, 16'h0102);
      send(8'h79);
      sent = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK_50);
         if (seq_busy) begin
            rx_data = 8'h7A;
            rx_ready = 1'b1;
            sent++;
            @(posedge CLK_50);
            #1 rx_ready = 1'b0;
         end
      end
      chk("drop300_sent", sent, 300);
      chk("drop300_dimension", dimension, 3'd1);
      wait_idle("drop300_idle");
      chk("drop300_cnt", drop_cnt, 8'd255);
      busy_len = 10;

      sample = 16'h7777;
      push_ack(8'h78, 16'h7777);
      send(8'h78);
      for (int n = 0; n < 3000 && start_t.size() < 2; n++) @(negedge CLK_50);
      chk("rst_reached_byte2", start_t.size(), 2);
      repeat (3) @(negedge CLK_50);
      #5 areset = 1'b1;
      #1 chk_reset("midreset");
      exp_q.delete();
      @(negedge CLK_50);
      areset = 1'b0;

      sample = 16'hCAFE;
      push_ack(8'h7A, 16'hCAFE);
      send(8'h7A);
      chk("z_dimension", dimension, 3'd2);
      wait_idle("z_idle");
      chk("z_nbytes", start_t.size(), ACK_N);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
